// File: rtl/updown_counter_param_if.sv
// Bus interface for updown_counter_param: control, bounds, count value and event flags.
// Carries cmp_val/cmp_hit only when UPDOWN_COUNTER_CMP_EN is defined.
interface updown_counter_param_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STEP_W = 8
);
  logic              en;
  logic              mode;
  logic              sat;
  logic              load;
  logic [WIDTH-1:0]  data;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;
  logic [STEP_W-1:0] step;
  logic              clr_flags;
  logic [WIDTH-1:0]  data_out;
  logic              wrap;
  logic              limit;
  logic              at_hi;
  logic              at_lo;
  logic              ovf_sticky;
  logic              cfg_err;
`ifdef UPDOWN_COUNTER_CMP_EN
  logic [WIDTH-1:0]  cmp_val;
  logic              cmp_hit;
`endif

  // Driver side: the block that programs and observes the counter.
  modport master (
    output en, mode, sat, load, data, lo, hi, step, clr_flags,
`ifdef UPDOWN_COUNTER_CMP_EN
    output cmp_val,
    input  cmp_hit,
`endif
    input  data_out, wrap, limit, at_hi, at_lo, ovf_sticky, cfg_err
  );

  // Counter side.
  modport slave (
    input  en, mode, sat, load, data, lo, hi, step, clr_flags,
`ifdef UPDOWN_COUNTER_CMP_EN
    input  cmp_val,
    output cmp_hit,
`endif
    output data_out, wrap, limit, at_hi, at_lo, ovf_sticky, cfg_err
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable bounds/step, wrap-or-saturate and event flags.
// Optional compare output enabled by defining UPDOWN_COUNTER_CMP_EN.
module updown_counter_param #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP_W    = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  updown_counter_param_if.slave cnt_if
);

  // Wide enough for count + step without modular overflow, whatever the step width.
  localparam int unsigned AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             limit_q, limit_d;
  logic             ovf_q, ovf_d;

  logic [AW-1:0]    step_ext;
  logic [AW-1:0]    cnt_ext;
  logic [AW-1:0]    lo_ext;
  logic [AW-1:0]    hi_ext;
  logic [AW-1:0]    up_sum;
  logic [AW-1:0]    down_floor;
  logic [AW-1:0]    down_diff;
  logic             cfg_err_c;
  logic             out_of_range_c;
  logic             count_upd_c;

  assign step_ext   = (cnt_if.step == '0) ? AW'(1) : AW'(cnt_if.step);
  assign cnt_ext    = AW'(cnt_q);
  assign lo_ext     = AW'(cnt_if.lo);
  assign hi_ext     = AW'(cnt_if.hi);
  assign up_sum     = cnt_ext + step_ext;
  assign down_floor = lo_ext + step_ext;
  assign down_diff  = cnt_ext - step_ext;

  assign cfg_err_c      = (cnt_if.lo > cnt_if.hi);
  assign out_of_range_c = (cnt_q < cnt_if.lo) || (cnt_q > cnt_if.hi);
  assign count_upd_c    = !cnt_if.load && cnt_if.en && !cfg_err_c;

  // Next count and event pulses: load beats counting, bad bounds freeze the count.
  always_comb begin
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    limit_d = 1'b0;
    if (cnt_if.load) begin
      cnt_d = cnt_if.data;
    end else if (count_upd_c) begin
      if (out_of_range_c) begin
        cnt_d = cnt_if.mode ? cnt_if.lo : cnt_if.hi;
      end else if (cnt_if.mode) begin
        if (up_sum <= hi_ext) begin
          cnt_d = WIDTH'(up_sum);
        end else if (cnt_if.sat) begin
          cnt_d   = cnt_if.hi;
          limit_d = 1'b1;
        end else begin
          cnt_d  = cnt_if.lo;
          wrap_d = 1'b1;
        end
      end else begin
        if (cnt_ext >= down_floor) begin
          cnt_d = WIDTH'(down_diff);
        end else if (cnt_if.sat) begin
          cnt_d   = cnt_if.lo;
          limit_d = 1'b1;
        end else begin
          cnt_d  = cnt_if.hi;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // A new event in the same cycle as a clear keeps the sticky flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (cnt_if.clr_flags) begin
      ovf_d = 1'b0;
    end
    if (wrap_d || limit_d) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= RESET_VAL;
      wrap_q  <= 1'b0;
      limit_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      limit_q <= limit_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef UPDOWN_COUNTER_CMP_EN
  logic cmp_hit_q, cmp_hit_d;

  // Pulse only when a count update moves the value onto cmp_val.
  always_comb begin
    cmp_hit_d = 1'b0;
    if (count_upd_c && (cnt_d == cnt_if.cmp_val) && (cnt_q != cnt_if.cmp_val)) begin
      cmp_hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_hit_q <= 1'b0;
    end else begin
      cmp_hit_q <= cmp_hit_d;
    end
  end

  assign cnt_if.cmp_hit = cmp_hit_q;
`endif

  assign cnt_if.data_out   = cnt_q;
  assign cnt_if.wrap       = wrap_q;
  assign cnt_if.limit      = limit_q;
  assign cnt_if.ovf_sticky = ovf_q;
  assign cnt_if.at_hi      = (cnt_q == cnt_if.hi);
  assign cnt_if.at_lo      = (cnt_q == cnt_if.lo);
  assign cnt_if.cfg_err    = cfg_err_c;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: an 8-bit instance for bounds/step/flags
// and a 32-bit full-range instance for legacy wrap behaviour.
module tb_updown_counter_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  updown_counter_param_if #(.WIDTH(8),  .STEP_W(8)) b8();
  updown_counter_param_if #(.WIDTH(32), .STEP_W(8)) b32();

  updown_counter_param #(.WIDTH(8),  .STEP_W(8), .RESET_VAL(8'h00))
    u8 (.clk(clk), .rst_n(rst_n), .cnt_if(b8));
  updown_counter_param #(.WIDTH(32), .STEP_W(8), .RESET_VAL(32'h0))
    u32 (.clk(clk), .rst_n(rst_n), .cnt_if(b32));

  typedef struct {
    string       tag;
    logic        sel32;
    logic [31:0] cnt;
    logic        wrap;
    logic        limit;
    logic        sticky;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push expectation, clock once, then pop and compare against the selected instance.
  task automatic step(input logic sel32, input string tag, input logic [31:0] cnt,
                      input logic w, input logic l, input logic s);
    exp_t e;
    exp_t x;
    e.tag = tag; e.sel32 = sel32; e.cnt = cnt; e.wrap = w; e.limit = l; e.sticky = s;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (x.sel32) begin
      chk({x.tag, ".cnt"},    b32.data_out,           x.cnt);
      chk({x.tag, ".wrap"},   32'(b32.wrap),          32'(x.wrap));
      chk({x.tag, ".limit"},  32'(b32.limit),         32'(x.limit));
      chk({x.tag, ".sticky"}, 32'(b32.ovf_sticky),    32'(x.sticky));
    end else begin
      chk({x.tag, ".cnt"},    32'(b8.data_out),       x.cnt);
      chk({x.tag, ".wrap"},   32'(b8.wrap),           32'(x.wrap));
      chk({x.tag, ".limit"},  32'(b8.limit),          32'(x.limit));
      chk({x.tag, ".sticky"}, 32'(b8.ovf_sticky),     32'(x.sticky));
    end
  endtask

  initial begin
    b8.en = 0; b8.mode = 1; b8.sat = 0; b8.load = 0; b8.data = '0;
    b8.lo = 8'h00; b8.hi = 8'hFF; b8.step = 8'd1; b8.clr_flags = 0;
    b32.en = 0; b32.mode = 1; b32.sat = 0; b32.load = 0; b32.data = '0;
    b32.lo = 32'h0; b32.hi = 32'hFFFF_FFFF; b32.step = 8'd0; b32.clr_flags = 0;
`ifdef UPDOWN_COUNTER_CMP_EN
    b8.cmp_val = '0; b32.cmp_val = '0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst8.cnt",    32'(b8.data_out),   32'h0);
    chk("rst8.sticky", 32'(b8.ovf_sticky), 32'h0);
    chk("rst32.cnt",   b32.data_out,       32'h0);
    @(negedge clk);
    rst_n = 1;
    #1;

    // Reset mid-count, then resume
    b8.load = 1; b8.data = 8'h37;
    step(0, "load37", 32'h37, 0, 0, 0);
    b8.load = 0;
    rst_n = 0;
    #1;
    chk("midrst.cnt",  32'(b8.data_out), 32'h0);
    chk("midrst.wrap", 32'(b8.wrap),     32'h0);
    @(negedge clk);
    rst_n = 1;
    b8.en = 1;
    step(0, "resume", 32'h01, 0, 0, 0);

    // Up wrap
    b8.en = 0; b8.lo = 8'h10; b8.hi = 8'h20; b8.step = 8'd3; b8.sat = 0; b8.mode = 1;
    b8.load = 1; b8.data = 8'h1E;
    step(0, "upw.load", 32'h1E, 0, 0, 0);
    b8.load = 0; b8.en = 1;
    step(0, "upw.wrap", 32'h10, 1, 0, 1);
    step(0, "upw.next", 32'h13, 0, 0, 1);

    // Up saturate, repeated clamp, clear, set-beats-clear
    b8.en = 0; b8.sat = 1; b8.load = 1; b8.data = 8'h1E;
    step(0, "ups.load", 32'h1E, 0, 0, 1);
    b8.load = 0; b8.en = 1;
    step(0, "ups.clamp", 32'h20, 0, 1, 1);
    step(0, "ups.again", 32'h20, 0, 1, 1);
    chk("ups.at_hi", 32'(b8.at_hi), 32'h1);
    b8.en = 0; b8.clr_flags = 1;
    step(0, "ups.clr", 32'h20, 0, 0, 0);
    b8.en = 1;
    step(0, "ups.setwins", 32'h20, 0, 1, 1);
    b8.en = 0;
    step(0, "ups.clr2", 32'h20, 0, 0, 0);
    b8.clr_flags = 0;

    // Down wrap, out-of-range recovery, in-range down, down saturate
    b8.sat = 0; b8.mode = 0; b8.load = 1; b8.data = 8'h12;
    step(0, "dn.load", 32'h12, 0, 0, 0);
    b8.load = 0; b8.en = 1;
    step(0, "dn.wrap", 32'h20, 1, 0, 1);
    step(0, "dn.step", 32'h1D, 0, 0, 1);
    b8.en = 0; b8.load = 1; b8.data = 8'h05;
    step(0, "oor.load", 32'h05, 0, 0, 1);
    b8.load = 0; b8.en = 1;
    step(0, "oor.tohi", 32'h20, 0, 0, 1);
    b8.en = 0; b8.sat = 1; b8.load = 1; b8.data = 8'h11;
    step(0, "dns.load", 32'h11, 0, 0, 1);
    b8.load = 0; b8.en = 1;
    step(0, "dns.clamp", 32'h10, 0, 1, 1);
    chk("dns.at_lo", 32'(b8.at_lo), 32'h1);

    // Load beats enable; cfg_err freezes the count but not loads
    b8.load = 1; b8.data = 8'hAA; b8.clr_flags = 1;
    step(0, "prio.load", 32'hAA, 0, 0, 0);
    b8.load = 0; b8.clr_flags = 0; b8.lo = 8'h30; b8.hi = 8'h20; b8.mode = 1;
    #1;
    chk("cfg_err", 32'(b8.cfg_err), 32'h1);
    for (int i = 0; i < 5; i++) step(0, "cfg.hold", 32'hAA, 0, 0, 0);
    b8.load = 1; b8.data = 8'h55;
    step(0, "cfg.load", 32'h55, 0, 0, 0);
    b8.load = 0; b8.lo = 8'h00; b8.hi = 8'hFF; b8.step = 8'd0;
    step(0, "step0", 32'h56, 0, 0, 0);

    // lo == hi: every enabled step is an event
    b8.lo = 8'h40; b8.hi = 8'h40; b8.sat = 0; b8.load = 1; b8.data = 8'h40;
    step(0, "eq.load", 32'h40, 0, 0, 0);
    b8.load = 0;
    step(0, "eq.wrap", 32'h40, 1, 0, 1);
    b8.sat = 1;
    step(0, "eq.limit", 32'h40, 0, 1, 1);
    b8.en = 0;

    // Legacy 32-bit full-range wrap
    b32.load = 1; b32.data = 32'hFFFF_FFFF;
    step(1, "leg.load", 32'hFFFF_FFFF, 0, 0, 0);
    b32.load = 0; b32.en = 1;
    step(1, "leg.upwrap", 32'h0, 1, 0, 1);
    b32.mode = 0;
    step(1, "leg.dnwrap", 32'hFFFF_FFFF, 1, 0, 1);
    step(1, "leg.dn", 32'hFFFF_FFFE, 0, 0, 1);
    b32.mode = 1;
    step(1, "leg.up", 32'hFFFF_FFFF, 0, 0, 1);
    b32.en = 0;

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard: observed %0d leftover expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter, successor to the fixed 32-bit up/down counter. Adds configurable width, runtime-programmable bounds and step, wrap-or-saturate limit policy, count enable, and event flags. Used as the generic counting primitive for timers and address/sequence generators; drop-in for the 32-bit case with default parameters and full-range bounds.

Parameters:
WIDTH, 32, counter/bound/data width in bits (2..64)
STEP_W, 8, width of step input
RESET_VAL, 0, count value after reset (must fit WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
en  input  1  count enable; no count change when low (load still honoured)
mode  input  1  1 = count up, 0 = count down
sat  input  1  1 = saturate at bound, 0 = wrap to opposite bound
load  input  1  synchronous load of data
data  input  WIDTH  load value
lo  input  WIDTH  lower bound (inclusive)
hi  input  WIDTH  upper bound (inclusive)
step  input  STEP_W  increment/decrement magnitude; 0 treated as 1
clr_flags  input  1  clears sticky flags
data_out  output  WIDTH  current count (registered)
wrap  output  1  one-cycle pulse: wrap occurred this update
limit  output  1  one-cycle pulse: saturation clamp occurred this update
at_hi  output  1  combinational, data_out == hi
at_lo  output  1  combinational, data_out == lo
ovf_sticky  output  1  sticky: any wrap/clamp since last clear
cfg_err  output  1  combinational, lo > hi

Behaviour:
- Reset (rst low, async): data_out = RESET_VAL; wrap = limit = ovf_sticky = 0. Release is synchronous to clk.
- Priority each rising edge: load > (en && !cfg_err) > hold.
- load: data_out <= data, no range check; wrap = limit = 0.
- cfg_err (lo > hi): count holds, no flags raised; load still works.
- Effective step s = (step == 0) ? 1 : step, zero-extended; arithmetic in WIDTH+1 bits, so no silent modular overflow.
- Out-of-range count (data_out < lo or > hi) with en: next data_out = lo if mode = 1, hi if mode = 0; no wrap/limit pulse.
- Up, in range: n = data_out + s. If n <= hi, data_out <= n. Else sat = 1: data_out <= hi, limit = 1; sat = 0: data_out <= lo, wrap = 1.
- Down, in range: if data_out >= lo + s, data_out <= data_out - s. Else sat = 1: data_out <= lo, limit = 1; sat = 0: data_out <= hi, wrap = 1.
- Sat mode already at bound and stepping outward: stays at bound, limit pulses every enabled cycle.
- lo == hi: every enabled step produces a wrap or limit event; data_out stays lo.
- wrap/limit: registered, asserted the same cycle the new data_out appears, cleared the next cycle unless re-triggered.
- ovf_sticky: set on wrap or limit; clr_flags clears it; set wins when both occur in the same cycle.
- Full range (lo = 0, hi = all-ones, step = 1, sat = 0) reproduces the legacy 32-bit wrap counter exactly.
- mode, sat, lo, hi, step are sampled every cycle; changes take effect on the next edge.

Optional Feature:
Macro UPDOWN_COUNTER_CMP_EN.
- Defined: adds input cmp_val [WIDTH] and output cmp_hit [1]. cmp_hit is a registered one-cycle pulse when data_out transitions to equal cmp_val through a count update (not a load).
- Not defined: neither port exists and no compare logic is built.

Test Plan:
- Reset mid-count: WIDTH=8, count at 0x37, pull rst low between edges -> data_out = 0x00 immediately, flags 0; counting resumes on the first edge after release.
- Up wrap: lo=0x10, hi=0x20, step=3, sat=0, load 0x1E, en=1 mode=1 -> 0x10 with wrap=1 for one cycle, ovf_sticky=1, next 0x13.
- Up saturate: same settings, sat=1 -> 0x20 with limit=1; the next enabled cycle stays 0x20 with limit=1 again; clr_flags with no new event -> ovf_sticky=0.
- Down wrap plus out-of-range: load 0x12, mode=0, step=3, sat=0 -> 0x0F? no: 0x12 < 0x10+3 gives 0x20 with wrap=1; then load 0x05, en -> 0x20 with no wrap pulse.
- Load/enable priority and cfg_err: load=1 and en=1 with data=0xAA -> 0xAA; lo=0x30, hi=0x20 -> cfg_err=1, count holds for 5 cycles; a load still takes effect.
- Legacy equivalence: WIDTH=32, full range, step=0 -> 0xFFFFFFFF +1 gives 0x00000000 with wrap; down from 0 gives 0xFFFFFFFF with wrap.
